// File: rtl/led_pkg.sv
// Shared definitions for the LED peripheral: register offsets, display modes
// and the base address used by the bus address decoder.
package led_pkg;

    // Word offsets within the LED window, decoded from addr[3:2]
    localparam logic [1:0] LED_VALUE_OFF  = 2'd0;
    localparam logic [1:0] LED_MODE_OFF   = 2'd1;
    localparam logic [1:0] LED_PERIOD_OFF = 2'd2;
    localparam logic [1:0] LED_COUNT_OFF  = 2'd3;

    // Base of the LED window on the core data bus
    localparam logic [31:0] LED_BASE_ADDR = 32'h8000_0800;

    typedef enum logic [1:0] {
        LED_STATIC = 2'd0,
        LED_BLINK  = 2'd1,
        LED_ROTATE = 2'd2
    } led_mode_t;

    // The unused encoding 3 is folded onto STATIC so MODE always holds a legal state
    function automatic led_mode_t led_decode_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    return LED_BLINK;
            2'd2:    return LED_ROTATE;
            default: return LED_STATIC;
        endcase
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Period counter for the LED display. Counts 0..period while running and
// emits a one-cycle tick on the cycle the count equals the period.
module led_tick_gen #(
    parameter int unsigned CNT_WIDTH = 24
) (
    input  logic                 clk_i,
    input  logic                 arstn_i,
    input  logic                 run_i,
    input  logic                 clear_i,
    input  logic [CNT_WIDTH-1:0] period_i,
    output logic                 tick_o,
    output logic [CNT_WIDTH-1:0] count_o
);

    logic [CNT_WIDTH-1:0] count_q, count_d;

    // Tick is raw here; the caller decides whether a simultaneous clear masks it
    assign tick_o  = run_i && (count_q == period_i);
    assign count_o = count_q;

    // Next count: hold at zero when stopped, wrap on tick, restart on clear
    always_comb begin
        count_d = count_q + CNT_WIDTH'(1);
        if (clear_i || !run_i || tick_o) begin
            count_d = '0;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/led_responder.sv
// Memory-mapped LED peripheral. Four word registers (VALUE, MODE, PERIOD,
// COUNT), fixed one-cycle response, and a static/blink/rotate LED display.
module led_responder
    import led_pkg::*;
#(
    parameter int unsigned          LED_WIDTH      = 16,
    parameter int unsigned          CNT_WIDTH      = 24,
    parameter logic [CNT_WIDTH-1:0] DEFAULT_PERIOD = CNT_WIDTH'(5_000_000)
) (
    input  logic                 clk_i,
    input  logic                 arstn_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [31:0]          addr_i,
    input  logic [31:0]          wdata_i,
    output logic                 rvalid_o,
    output logic [31:0]          rdata_o,
    output logic [LED_WIDTH-1:0] led_o
);

    logic [LED_WIDTH-1:0] value_q, value_d;
    led_mode_t            mode_q, mode_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic                 phase_q, phase_d;
    logic [LED_WIDTH-1:0] shadow_q, shadow_d;
    logic                 rvalid_q;
    logic [31:0]          rdata_q, rdata_d;
    logic [LED_WIDTH-1:0] led_q, led_d;

    logic [1:0]           off;
    logic                 wr_value, wr_mode, wr_period, rd;
    logic                 cnt_clear, tick, tick_eff;
    logic [CNT_WIDTH-1:0] count;

    // Only addr[3:2] and the low register bits of wdata are meaningful
    logic unused_bus_bits;
    assign unused_bus_bits = ^{addr_i, wdata_i};

    assign off       = addr_i[3:2];
    assign rd        = req_i && !we_i;
    assign wr_value  = req_i && we_i && (off == LED_VALUE_OFF);
    assign wr_mode   = req_i && we_i && (off == LED_MODE_OFF);
    assign wr_period = req_i && we_i && (off == LED_PERIOD_OFF);

    // Reconfiguring the timing restarts the period from a clean ON phase
    assign cnt_clear = wr_mode || wr_period;
    assign tick_eff  = tick && !cnt_clear;

    led_tick_gen #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_tick_gen (
        .clk_i    (clk_i),
        .arstn_i  (arstn_i),
        .run_i    (mode_q != LED_STATIC),
        .clear_i  (cnt_clear),
        .period_i (period_q),
        .tick_o   (tick),
        .count_o  (count)
    );

    function automatic logic [LED_WIDTH-1:0] rotl1(input logic [LED_WIDTH-1:0] v);
        return (v << 1) | (v >> (LED_WIDTH - 1));
    endfunction

    // Register writes and display state update; led_d is derived from next-state values
    always_comb begin
        value_d  = value_q;
        mode_d   = mode_q;
        period_d = period_q;
        phase_d  = phase_q;
        shadow_d = shadow_q;

        if (wr_value) begin
            value_d = wdata_i[LED_WIDTH-1:0];
        end
        if (wr_mode) begin
            mode_d = led_decode_mode(wdata_i[1:0]);
        end
        if (wr_period) begin
            period_d = wdata_i[CNT_WIDTH-1:0];
        end

        if (cnt_clear) begin
            phase_d = 1'b1;
        end else if (tick_eff && (mode_q == LED_BLINK)) begin
            phase_d = !phase_q;
        end

        // A load of the rotation pattern beats a rotate step in the same cycle
        if ((wr_mode && (mode_d == LED_ROTATE)) || (wr_value && (mode_q == LED_ROTATE))) begin
            shadow_d = value_d;
        end else if (tick_eff && (mode_q == LED_ROTATE)) begin
            shadow_d = rotl1(shadow_q);
        end

        led_d = value_d;
        unique case (mode_d)
            LED_STATIC: led_d = value_d;
            LED_BLINK:  led_d = phase_d ? value_d : '0;
            LED_ROTATE: led_d = shadow_d;
            default:    led_d = value_d;
        endcase
    end

    // Read mux samples pre-write contents; write responses carry zero data
    always_comb begin
        rdata_d = '0;
        if (rd) begin
            unique case (off)
                LED_VALUE_OFF:  rdata_d[LED_WIDTH-1:0] = value_q;
                LED_MODE_OFF:   rdata_d[1:0]           = mode_q;
                LED_PERIOD_OFF: rdata_d[CNT_WIDTH-1:0] = period_q;
                LED_COUNT_OFF:  rdata_d[CNT_WIDTH-1:0] = count;
                default:        rdata_d = '0;
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            value_q  <= '0;
            mode_q   <= LED_STATIC;
            period_q <= DEFAULT_PERIOD;
            phase_q  <= 1'b1;
            shadow_q <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            led_q    <= '0;
        end else begin
            value_q  <= value_d;
            mode_q   <= mode_d;
            period_q <= period_d;
            phase_q  <= phase_d;
            shadow_q <= shadow_d;
            rvalid_q <= req_i;
            rdata_q  <= rdata_d;
            led_q    <= led_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign led_o    = led_q;

endmodule

// File: tb/tb_led_responder.sv
// Bench for led_responder: directed literal checks plus randomized traffic
// compared every cycle against an elapsed-time model of the display.
module tb_led_responder;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        rvalid;
    logic [31:0] rdata;
    logic [15:0] led;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    led_responder dut (
        .clk_i    (clk),
        .arstn_i  (arstn),
        .req_i    (req),
        .we_i     (we),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .rvalid_o (rvalid),
        .rdata_o  (rdata),
        .led_o    (led)
    );

    // ---------------- behavioural model ----------------
    // m_e counts edges since the last counter restart; count and tick totals follow from it.
    logic [15:0] m_value;
    int          m_mode;
    longint      m_period;
    longint      m_e;
    logic [15:0] m_rot_src;
    longint      m_rot_base;
    bit          m_rvalid;
    bit          m_read;
    logic [31:0] m_rdata;

    function automatic longint m_ticks();
        return m_e / (m_period + 1);
    endfunction

    function automatic logic [15:0] rotl_n(input logic [15:0] v, input longint n);
        logic [15:0] r;
        int          k;
        r = v;
        k = int'(n % 16);
        for (int i = 0; i < k; i++) r = {r[14:0], r[15]};
        return r;
    endfunction

    function automatic logic [15:0] m_led();
        case (m_mode)
            1:       return (m_ticks() % 2 == 0) ? m_value : 16'h0;
            2:       return rotl_n(m_rot_src, m_ticks() - m_rot_base);
            default: return m_value;
        endcase
    endfunction

    task automatic model_reset();
        m_value    = 16'h0;
        m_mode     = 0;
        m_period   = 5000000;
        m_e        = 0;
        m_rot_src  = 16'h0;
        m_rot_base = 0;
        m_rvalid   = 1'b0;
        m_read     = 1'b0;
        m_rdata    = 32'h0;
    endtask

    task automatic model_step();
        logic [1:0] off;
        bit         wr;
        off      = addr[3:2];
        wr       = req && we;
        m_rvalid = req;
        m_read   = req && !we;
        case (off)
            2'd0:    m_rdata = {16'h0, m_value};
            2'd1:    m_rdata = 32'(m_mode);
            2'd2:    m_rdata = 32'(m_period);
            default: m_rdata = 32'(m_e % (m_period + 1));
        endcase
        if (wr && (off == 2'd1 || off == 2'd2)) begin
            // Freeze the pattern currently shown before restarting the time base
            if (m_mode == 2) m_rot_src = m_led();
            m_rot_base = 0;
            m_e        = 0;
            if (off == 2'd1) begin
                m_mode = (wdata[1:0] == 2'd3) ? 0 : int'(wdata[1:0]);
                if (m_mode == 2) m_rot_src = m_value;
            end else begin
                m_period = longint'(wdata[23:0]);
            end
        end else begin
            if (m_mode != 0) m_e++;
            if (wr && off == 2'd0) begin
                m_value = wdata[15:0];
                if (m_mode == 2) begin
                    m_rot_src  = m_value;
                    m_rot_base = m_ticks();
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge arstn);
            if (!arstn) model_reset();
            else model_step();
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            chk("cyc rvalid", {31'h0, rvalid}, {31'h0, m_rvalid});
            if (m_rvalid && m_read) chk("cyc rdata", rdata, m_rdata);
            else if (!m_rvalid) chk("cyc rdata idle", rdata, 32'h0);
            chk("cyc led", {16'h0, led}, {16'h0, m_led()});
        end
    end

    // ---------------- stimulus ----------------
    // One-cycle request starting at a negedge; returns at the next negedge
    task automatic bus(input bit w, input logic [1:0] off, input logic [31:0] d);
        req   = 1'b1;
        we    = w;
        addr  = 32'h8000_0800 | {28'h0, off, 2'b00};
        wdata = d;
        @(negedge clk);
        req = 1'b0;
        we  = 1'b0;
    endtask

    task automatic rd_expect(input string name, input logic [1:0] off, input logic [31:0] exp);
        bus(1'b0, off, 32'h0);
        chk({name, " rvalid"}, {31'h0, rvalid}, 32'h1);
        chk(name, rdata, exp);
    endtask

    logic [31:0] cnt_exp [5] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    logic [15:0] blink_exp [9] = '{16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF,
                                   16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h00FF};

    initial begin
        arstn = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset led", {16'h0, led}, 32'h0);
        chk("reset rvalid", {31'h0, rvalid}, 32'h0);
        arstn = 1'b1;
        @(negedge clk);

        rd_expect("rst VALUE", 2'd0, 32'h0);
        rd_expect("rst MODE", 2'd1, 32'h0);
        rd_expect("rst PERIOD", 2'd2, 32'd5_000_000);
        rd_expect("rst COUNT", 2'd3, 32'h0);

        bus(1'b1, 2'd0, 32'h0000_A5A5);
        chk("static led", {16'h0, led}, 32'h0000_A5A5);
        rd_expect("VALUE readback", 2'd0, 32'h0000_A5A5);
        bus(1'b1, 2'd0, 32'hFFFF_1234);
        rd_expect("VALUE truncated", 2'd0, 32'h0000_1234);

        // Blink, PERIOD=3
        bus(1'b1, 2'd2, 32'd3);
        bus(1'b1, 2'd0, 32'h0000_00FF);
        bus(1'b1, 2'd1, 32'd1);
        for (int i = 0; i < 5; i++) rd_expect("blink COUNT", 2'd3, cnt_exp[i]);
        bus(1'b1, 2'd1, 32'd1);
        for (int i = 0; i < 9; i++) begin
            chk("blink led", {16'h0, led}, {16'h0, blink_exp[i]});
            @(negedge clk);
        end

        // Rotate, PERIOD=0
        bus(1'b1, 2'd2, 32'd0);
        bus(1'b1, 2'd0, 32'h0000_8001);
        bus(1'b1, 2'd1, 32'd2);
        chk("rot led 0", {16'h0, led}, 32'h8001);
        @(negedge clk);
        chk("rot led 1", {16'h0, led}, 32'h0003);
        @(negedge clk);
        chk("rot led 2", {16'h0, led}, 32'h0006);
        bus(1'b1, 2'd0, 32'h0000_0010);
        chk("rot reload", {16'h0, led}, 32'h0010);
        @(negedge clk);
        chk("rot resume", {16'h0, led}, 32'h0020);

        // MODE=3 folds to STATIC
        bus(1'b1, 2'd1, 32'd3);
        rd_expect("MODE 3", 2'd1, 32'h0);
        chk("mode3 led", {16'h0, led}, 32'h0010);

        // COUNT is read-only
        bus(1'b1, 2'd2, 32'd100);
        bus(1'b1, 2'd1, 32'd1);
        repeat (5) @(negedge clk);
        bus(1'b1, 2'd3, 32'h0);
        rd_expect("COUNT ro", 2'd3, 32'd6);

        // Asynchronous reset in the middle of blinking with a response pending
        bus(1'b1, 2'd2, 32'd3);
        bus(1'b1, 2'd1, 32'd1);
        repeat (2) @(negedge clk);
        req  = 1'b1;
        we   = 1'b0;
        addr = 32'h8000_080C;
        @(posedge clk);
        #3 arstn = 1'b0;
        #1;
        chk("arst led", {16'h0, led}, 32'h0);
        chk("arst rvalid", {31'h0, rvalid}, 32'h0);
        chk("arst rdata", rdata, 32'h0);
        req = 1'b0;
        @(negedge clk);
        arstn = 1'b1;
        rd_expect("post-reset PERIOD", 2'd2, 32'd5_000_000);
        rd_expect("post-reset COUNT", 2'd3, 32'h0);

        // Randomized traffic, checked by the per-cycle compare
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 6) begin
                logic [1:0]  off;
                logic [31:0] d;
                off = 2'($urandom_range(0, 3));
                case (off)
                    2'd1:    d = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
                    2'd2:    d = ($urandom & 32'hFF00_0000) | 32'($urandom_range(0, 5));
                    default: d = $urandom;
                endcase
                bus(($urandom_range(0, 1) == 1), off, d);
            end else begin
                @(negedge clk);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
